// File: rtl/uart_xintf_pkg.sv
// Shared constants and FSM state types for the UART <-> XINTF frame path.
package uart_xintf_pkg;

    localparam logic [7:0]  DEF_HDR0          = 8'hEB;
    localparam logic [7:0]  DEF_HDR1          = 8'h90;
    // Must match xintf_top's U2X_FBYTE_NUM.
    localparam int unsigned DEF_FRAME_LEN     = 22;
    localparam int unsigned DEF_X2U_FRAME_LEN = 22;
    // 1 ms at 50 MHz.
    localparam int unsigned DEF_TIMEOUT_CYC   = 50000;

    typedef enum logic [2:0] {
        R_HDR0,
        R_HDR1,
        R_HWR,
        R_BODY,
        R_PAD
    } rx_state_t;

    typedef enum logic [2:0] {
        T_IDLE,
        T_RD,
        T_LAT,
        T_SEND,
        T_HOLD
    } tx_state_t;

endpackage

// File: rtl/x2u_tx_sched.sv
// Drains one full XINTF->UART frame from FIFO2 into the UART transmitter.
module x2u_tx_sched
    import uart_xintf_pkg::*;
#(
    parameter int unsigned X2U_FRAME_LEN = DEF_X2U_FRAME_LEN
) (
    input  logic       clk50M,
    input  logic       rst_n,
    input  logic [7:0] fifo2_cnt,
    input  logic [7:0] f2_buf_out,
    input  logic       tx_busy,
    output logic       f2_rd_en,
    output logic       tx_start,
    output logic [7:0] tx_data
);

    localparam logic [7:0] XLEN = 8'(X2U_FRAME_LEN);

    tx_state_t  tx_state;
    logic [7:0] tx_cnt;

    // TX frame sequencer: read, latch, start, wait for the byte to go out.
    // f2_rd_en is registered on the transition into T_RD so it is high
    // exactly while in T_RD and FIFO data is valid during T_LAT.
    // In T_HOLD the still-high tx_start marks the one-cycle wait before
    // tx_busy rises.
    always_ff @(posedge clk50M or negedge rst_n) begin
        if (!rst_n) begin
            tx_state <= T_IDLE;
            tx_cnt   <= '0;
            f2_rd_en <= 1'b0;
            tx_start <= 1'b0;
            tx_data  <= '0;
        end else begin
            f2_rd_en <= 1'b0;
            tx_start <= 1'b0;
            case (tx_state)
                T_IDLE: begin
                    tx_cnt <= '0;
                    if (fifo2_cnt >= XLEN) begin
                        f2_rd_en <= 1'b1;
                        tx_state <= T_RD;
                    end
                end
                T_RD: begin
                    tx_state <= T_LAT;
                end
                T_LAT: begin
                    tx_data  <= f2_buf_out;
                    tx_state <= T_SEND;
                end
                T_SEND: begin
                    if (!tx_busy) begin
                        tx_start <= 1'b1;
                        tx_state <= T_HOLD;
                    end
                end
                T_HOLD: begin
                    if (!tx_start && !tx_busy) begin
                        tx_cnt <= tx_cnt + 8'd1;
                        if (tx_cnt + 8'd1 == XLEN) begin
                            tx_state <= T_IDLE;
                        end else begin
                            f2_rd_en <= 1'b1;
                            tx_state <= T_RD;
                        end
                    end
                end
                default: begin
                    tx_state <= T_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/uart_xintf_ctrl.sv
// Frame sequencer between the UART byte interfaces and xintf_top's FIFOs.
// RX: header hunt, whole-frame writes into FIFO1 with zero padding on
// timeout. TX: delegated to x2u_tx_sched.
module uart_xintf_ctrl
    import uart_xintf_pkg::*;
#(
    parameter int unsigned FRAME_LEN     = DEF_FRAME_LEN,
    parameter int unsigned X2U_FRAME_LEN = DEF_X2U_FRAME_LEN,
    parameter logic [7:0]  HDR0          = DEF_HDR0,
    parameter logic [7:0]  HDR1          = DEF_HDR1,
    parameter int unsigned TIMEOUT_CYC   = DEF_TIMEOUT_CYC
) (
    input  logic       clk50M,
    input  logic       rst_n,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic       f1_wr_en,
    output logic [7:0] f1_buf_in,
    output logic       f2_rd_en,
    input  logic [7:0] f2_buf_out,
    input  logic [7:0] fifo2_cnt,
    input  logic       tx_busy,
    output logic       tx_start,
    output logic [7:0] tx_data,
    output logic       frame_ok,
    output logic       frame_err
);

    localparam int unsigned TW   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYC);
    localparam logic [7:0] FLEN  = 8'(FRAME_LEN);

    rx_state_t   rx_state;
    logic [7:0]  rx_cnt;
    logic [TW-1:0] tcnt;
    logic        tmo;

    // Inter-byte timeout reached.
    always_comb begin
        tmo = (tcnt == TMAX);
    end

    // RX framer: header hunt, header replay, body copy, zero padding.
    // The timeout check precedes rx_valid so a byte coinciding with the
    // timeout is dropped.
    always_ff @(posedge clk50M or negedge rst_n) begin
        if (!rst_n) begin
            rx_state  <= R_HDR0;
            rx_cnt    <= '0;
            tcnt      <= '0;
            f1_wr_en  <= 1'b0;
            f1_buf_in <= '0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            f1_wr_en  <= 1'b0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            case (rx_state)
                R_HDR0: begin
                    tcnt   <= '0;
                    rx_cnt <= '0;
                    if (rx_valid && rx_data == HDR0) begin
                        rx_state <= R_HDR1;
                    end
                end
                R_HDR1: begin
                    if (tmo) begin
                        rx_state <= R_HDR0;
                    end else if (rx_valid) begin
                        tcnt <= '0;
                        if (rx_data == HDR1) begin
                            rx_state <= R_HWR;
                        end else if (rx_data != HDR0) begin
                            rx_state <= R_HDR0;
                        end
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                R_HWR: begin
                    f1_wr_en  <= 1'b1;
                    f1_buf_in <= (rx_cnt == 8'd0) ? HDR0 : HDR1;
                    rx_cnt    <= rx_cnt + 8'd1;
                    if (rx_cnt == 8'd1) begin
                        tcnt     <= '0;
                        rx_state <= R_BODY;
                    end
                end
                R_BODY: begin
                    if (tmo) begin
                        frame_err <= 1'b1;
                        rx_state  <= R_PAD;
                    end else if (rx_valid) begin
                        tcnt      <= '0;
                        f1_wr_en  <= 1'b1;
                        f1_buf_in <= rx_data;
                        rx_cnt    <= rx_cnt + 8'd1;
                        if (rx_cnt + 8'd1 == FLEN) begin
                            frame_ok <= 1'b1;
                            rx_state <= R_HDR0;
                        end
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                R_PAD: begin
                    f1_wr_en  <= 1'b1;
                    f1_buf_in <= '0;
                    rx_cnt    <= rx_cnt + 8'd1;
                    if (rx_cnt + 8'd1 == FLEN) begin
                        rx_state <= R_HDR0;
                    end
                end
                default: begin
                    rx_state <= R_HDR0;
                end
            endcase
        end
    end

    x2u_tx_sched #(
        .X2U_FRAME_LEN(X2U_FRAME_LEN)
    ) u_tx_sched (
        .clk50M    (clk50M),
        .rst_n     (rst_n),
        .fifo2_cnt (fifo2_cnt),
        .f2_buf_out(f2_buf_out),
        .tx_busy   (tx_busy),
        .f2_rd_en  (f2_rd_en),
        .tx_start  (tx_start),
        .tx_data   (tx_data)
    );

endmodule

// File: tb/tb_uart_xintf_ctrl.sv
// Directed bench for uart_xintf_ctrl with FIFO2 and UART TX models.
module tb_uart_xintf_ctrl;

    logic       clk50M = 1'b0;
    logic       rst_n;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       f1_wr_en;
    logic [7:0] f1_buf_in;
    logic       f2_rd_en;
    logic [7:0] f2_buf_out = 8'h00;
    logic [7:0] fifo2_cnt;
    logic       tx_busy;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       frame_ok;
    logic       frame_err;

    int total = 0;
    int bad   = 0;

    // monitor state
    logic [7:0] f1_q[$];
    logic [7:0] tx_q[$];
    int ok_cnt  = 0;
    int ok_nowr = 0;
    int ok_at   = 0;
    int err_cnt = 0;
    int rd_cnt  = 0;
    int tx_viol = 0;

    // FIFO2 model state
    int f2_rdptr = 0;
    int f2_base  = 0;
    int f2_fill  = 0;

    // UART TX model state
    int bcnt;

    uart_xintf_ctrl dut (
        .clk50M    (clk50M),
        .rst_n     (rst_n),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .f1_wr_en  (f1_wr_en),
        .f1_buf_in (f1_buf_in),
        .f2_rd_en  (f2_rd_en),
        .f2_buf_out(f2_buf_out),
        .fifo2_cnt (fifo2_cnt),
        .tx_busy   (tx_busy),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .frame_ok  (frame_ok),
        .frame_err (frame_err)
    );

    always #10 clk50M = ~clk50M;

    assign fifo2_cnt = 8'(f2_fill - f2_rdptr);

    // FIFO2: registered read data, byte value = offset from load point
    always @(posedge clk50M) begin
        if (f2_rd_en) begin
            f2_buf_out <= 8'(f2_rdptr - f2_base);
            f2_rdptr   <= f2_rdptr + 1;
        end
    end

    // UART TX: busy rises the cycle after tx_start, lasts 12 cycles
    always @(posedge clk50M or negedge rst_n) begin
        if (!rst_n) begin
            tx_busy <= 1'b0;
            bcnt    <= 0;
        end else if (tx_start) begin
            tx_busy <= 1'b1;
            bcnt    <= 12;
        end else if (bcnt > 1) begin
            bcnt <= bcnt - 1;
        end else begin
            bcnt    <= 0;
            tx_busy <= 1'b0;
        end
    end

    // Output monitor, sampled mid-cycle
    always @(negedge clk50M) begin
        if (f1_wr_en) f1_q.push_back(f1_buf_in);
        if (frame_ok) begin
            ok_cnt++;
            ok_at = f1_q.size();
            if (!f1_wr_en) ok_nowr++;
        end
        if (frame_err) err_cnt++;
        if (f2_rd_en) rd_cnt++;
        if (tx_start) begin
            tx_q.push_back(tx_data);
            if (tx_busy) tx_viol++;
        end
        if (tx_busy && tx_q.size() > 0 && tx_data !== tx_q[$]) tx_viol++;
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk50M);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk50M);
        rx_valid = 1'b0;
        repeat (9) @(negedge clk50M);
    endtask

    task automatic test_reset();
        logic [20:0] outs;
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(negedge clk50M);
        outs = {f1_wr_en, f1_buf_in, f2_rd_en, tx_start, tx_data, frame_ok, frame_err};
        total++;
        if (outs !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got %h want 0", outs);
        end
        rst_n = 1'b1;
        repeat (20) @(negedge clk50M);
        total++;
        if (f1_q.size() != 0 || rd_cnt != 0 || tx_q.size() != 0) begin
            bad++;
            $display("FAIL reset_idle: got wr=%0d rd=%0d tx=%0d want 0 0 0",
                     f1_q.size(), rd_cnt, tx_q.size());
        end
    endtask

    task automatic test_rx_frame();
        int n0 = f1_q.size();
        int k0 = ok_cnt;
        int w0 = ok_nowr;
        logic [7:0] exp;
        send_byte(8'hEB);
        send_byte(8'h90);
        for (int i = 1; i <= 20; i++) send_byte(8'(i));
        repeat (5) @(negedge clk50M);
        total++;
        if (f1_q.size() - n0 != 22) begin
            bad++;
            $display("FAIL rx_frame_len: got %0d want 22", f1_q.size() - n0);
        end
        for (int i = 0; i < 22 && n0 + i < f1_q.size(); i++) begin
            exp = (i == 0) ? 8'hEB : (i == 1) ? 8'h90 : 8'(i - 1);
            total++;
            if (f1_q[n0+i] !== exp) begin
                bad++;
                $display("FAIL rx_frame_byte%0d: got %02h want %02h", i, f1_q[n0+i], exp);
            end
        end
        total++;
        if (ok_cnt - k0 != 1 || ok_nowr != w0 || ok_at != n0 + 22) begin
            bad++;
            $display("FAIL rx_frame_ok: got pulses=%0d nowr=%0d at=%0d want 1 0 %0d",
                     ok_cnt - k0, ok_nowr - w0, ok_at, n0 + 22);
        end
    endtask

    task automatic test_resync();
        int n0 = f1_q.size();
        logic [7:0] exp;
        send_byte(8'hEB);
        send_byte(8'hEB);
        send_byte(8'h90);
        for (int i = 1; i <= 20; i++) send_byte(8'(8'h40 + i));
        repeat (5) @(negedge clk50M);
        total++;
        if (f1_q.size() - n0 != 22) begin
            bad++;
            $display("FAIL resync_len: got %0d want 22", f1_q.size() - n0);
        end
        for (int i = 0; i < 22 && n0 + i < f1_q.size(); i++) begin
            exp = (i == 0) ? 8'hEB : (i == 1) ? 8'h90 : 8'(8'h3F + i);
            total++;
            if (f1_q[n0+i] !== exp) begin
                bad++;
                $display("FAIL resync_byte%0d: got %02h want %02h", i, f1_q[n0+i], exp);
            end
        end
    endtask

    task automatic test_timeout();
        int n0 = f1_q.size();
        int e0 = err_cnt;
        int k0 = ok_cnt;
        logic [7:0] exp;
        send_byte(8'hEB);
        send_byte(8'h90);
        for (int i = 1; i <= 5; i++) send_byte(8'(8'hA0 + i));
        for (int c = 0; c < 50100 && err_cnt == e0; c++) @(negedge clk50M);
        total++;
        if (err_cnt - e0 != 1) begin
            bad++;
            $display("FAIL timeout_err: got %0d pulses want 1", err_cnt - e0);
        end
        total++;
        if (f1_q.size() - n0 != 7) begin
            bad++;
            $display("FAIL timeout_pre_pad: got %0d writes want 7", f1_q.size() - n0);
        end
        repeat (15) @(negedge clk50M);
        total++;
        if (f1_q.size() - n0 != 22) begin
            bad++;
            $display("FAIL timeout_pad_burst: got %0d writes want 22", f1_q.size() - n0);
        end
        repeat (20) @(negedge clk50M);
        total++;
        if (f1_q.size() - n0 != 22 || ok_cnt != k0) begin
            bad++;
            $display("FAIL timeout_total: got %0d writes %0d ok want 22 0",
                     f1_q.size() - n0, ok_cnt - k0);
        end
        for (int i = 0; i < 22 && n0 + i < f1_q.size(); i++) begin
            exp = (i == 0) ? 8'hEB : (i == 1) ? 8'h90 :
                  (i < 7) ? 8'(8'h9F + i) : 8'h00;
            total++;
            if (f1_q[n0+i] !== exp) begin
                bad++;
                $display("FAIL timeout_byte%0d: got %02h want %02h", i, f1_q[n0+i], exp);
            end
        end
        test_rx_frame();
    endtask

    task automatic test_tx();
        int r0 = rd_cnt;
        int s0 = tx_q.size();
        int v0 = tx_viol;
        f2_base = f2_rdptr;
        f2_fill = f2_rdptr + 21;
        repeat (60) @(negedge clk50M);
        total++;
        if (rd_cnt != r0 || tx_q.size() != s0) begin
            bad++;
            $display("FAIL tx_below_thresh: got rd=%0d start=%0d want 0 0",
                     rd_cnt - r0, tx_q.size() - s0);
        end
        f2_fill = f2_rdptr + 22;
        for (int c = 0; c < 2000 && tx_q.size() - s0 < 22; c++) @(negedge clk50M);
        repeat (100) @(negedge clk50M);
        total++;
        if (tx_q.size() - s0 != 22 || rd_cnt - r0 != 22) begin
            bad++;
            $display("FAIL tx_count: got start=%0d rd=%0d want 22 22",
                     tx_q.size() - s0, rd_cnt - r0);
        end
        for (int i = 0; i < 22 && s0 + i < tx_q.size(); i++) begin
            total++;
            if (tx_q[s0+i] !== 8'(i)) begin
                bad++;
                $display("FAIL tx_byte%0d: got %02h want %02h", i, tx_q[s0+i], 8'(i));
            end
        end
        total++;
        if (tx_viol != v0 || fifo2_cnt !== 8'd0) begin
            bad++;
            $display("FAIL tx_handshake: got viol=%0d fifo2_cnt=%0d want 0 0",
                     tx_viol - v0, fifo2_cnt);
        end
    endtask

    task automatic test_reset_mid();
        int n0 = f1_q.size();
        int s0 = tx_q.size();
        int n1;
        int t1;
        logic [20:0] outs;
        f2_base = f2_rdptr;
        f2_fill = f2_rdptr + 22;
        fork
            begin
                send_byte(8'hEB);
                send_byte(8'h90);
                send_byte(8'h11);
                send_byte(8'h22);
                send_byte(8'h33);
            end
            begin
                for (int c = 0; c < 1000 && tx_q.size() - s0 < 3; c++) @(negedge clk50M);
            end
        join
        @(negedge clk50M);
        n1 = f1_q.size();
        t1 = tx_q.size();
        total++;
        if (n1 - n0 != 5 || t1 - s0 < 3 || t1 - s0 >= 22) begin
            bad++;
            $display("FAIL mid_setup: got wr=%0d start=%0d want 5 3..21", n1 - n0, t1 - s0);
        end
        rst_n = 1'b0;
        #1;
        outs = {f1_wr_en, f1_buf_in, f2_rd_en, tx_start, tx_data, frame_ok, frame_err};
        total++;
        if (outs !== '0) begin
            bad++;
            $display("FAIL mid_reset_outputs: got %h want 0", outs);
        end
        f2_fill = f2_rdptr;
        repeat (3) @(negedge clk50M);
        rst_n = 1'b1;
        repeat (300) @(negedge clk50M);
        total++;
        if (f1_q.size() != n1 || tx_q.size() != t1) begin
            bad++;
            $display("FAIL mid_after_release: got wr=%0d start=%0d want 0 0",
                     f1_q.size() - n1, tx_q.size() - t1);
        end
    endtask

    task automatic test_back_to_back();
        int n0 = f1_q.size();
        int k0 = ok_cnt;
        int s0 = tx_q.size();
        int v0 = tx_viol;
        logic [7:0] exp;
        f2_base = f2_rdptr;
        f2_fill = f2_rdptr + 22;
        fork
            begin
                send_byte(8'hEB);
                send_byte(8'h90);
                for (int i = 1; i <= 20; i++) send_byte(8'(8'h80 + i));
            end
            begin
                for (int c = 0; c < 2000 && tx_q.size() - s0 < 22; c++) @(negedge clk50M);
            end
        join
        repeat (100) @(negedge clk50M);
        total++;
        if (f1_q.size() - n0 != 22 || ok_cnt - k0 != 1) begin
            bad++;
            $display("FAIL b2b_rx: got wr=%0d ok=%0d want 22 1", f1_q.size() - n0, ok_cnt - k0);
        end
        for (int i = 0; i < 22 && n0 + i < f1_q.size(); i++) begin
            exp = (i == 0) ? 8'hEB : (i == 1) ? 8'h90 : 8'(8'h7F + i);
            total++;
            if (f1_q[n0+i] !== exp) begin
                bad++;
                $display("FAIL b2b_rx_byte%0d: got %02h want %02h", i, f1_q[n0+i], exp);
            end
        end
        total++;
        if (tx_q.size() - s0 != 22 || tx_viol != v0) begin
            bad++;
            $display("FAIL b2b_tx: got start=%0d viol=%0d want 22 0",
                     tx_q.size() - s0, tx_viol - v0);
        end
        for (int i = 0; i < 22 && s0 + i < tx_q.size(); i++) begin
            total++;
            if (tx_q[s0+i] !== 8'(i)) begin
                bad++;
                $display("FAIL b2b_tx_byte%0d: got %02h want %02h", i, tx_q[s0+i], 8'(i));
            end
        end
    endtask

    initial begin
        test_reset();
        test_rx_frame();
        test_resync();
        test_timeout();
        test_tx();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
